// File: rtl/match_result_fifo.sv
// -----------------------------------------------------------------------------
// match_result_fifo
//
// Purpose:
//   Captures words from the matching controller into a first-word-fall-through
//   FIFO. Each entry stores the word together with a 32-bit timestamp taken
//   from a free-running cycle counter. The software-side register block pops
//   entries one at a time. The block also keeps saturating statistics: words
//   accepted and words dropped because the FIFO was full.
//
// Ports:
//   i_fclk            sole clock, rising edge
//   i_reset_n         synchronous active-low reset (highest priority)
//   i_wr_valid        one-cycle capture strobe per matched word
//   i_wr_data         matched word, sampled with i_wr_valid
//   i_rd_en           pop request; ignored while empty
//   i_flush           discard all entries (statistics kept)
//   i_counter_reset   clear statistics and the timestamp counter
//   o_rd_data         head-entry data (don't-care while empty)
//   o_rd_stamp        head-entry timestamp (don't-care while empty)
//   o_empty / o_full  registered flags derived from the level
//   o_level           current entry count, 0..DEPTH
//   o_irq             level flag, o_level >= IRQ_THRESHOLD
//   o_capture_count   accepted words since last clear, saturating
//   o_drop_count      words dropped on full since last clear, saturating
//
// Handshake:
//   Write side has no back-pressure: a word is offered for exactly the cycle
//   i_wr_valid is high. It is stored when the FIFO is not full, or when it is
//   full and a pop happens in the same cycle; otherwise it is counted as a
//   drop. Read side: a pop happens on a cycle with i_rd_en=1 and o_empty=0;
//   o_rd_data/o_rd_stamp show the entry being popped during that cycle.
//   i_flush suppresses both the write and the read of its cycle.
// -----------------------------------------------------------------------------
module match_result_fifo #(
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH         = 16,
  parameter int IRQ_THRESHOLD = 8
) (
  input  logic                     i_fclk,
  input  logic                     i_reset_n,
  input  logic                     i_wr_valid,
  input  logic [DATA_WIDTH-1:0]    i_wr_data,
  input  logic                     i_rd_en,
  input  logic                     i_flush,
  input  logic                     i_counter_reset,
  output logic [DATA_WIDTH-1:0]    o_rd_data,
  output logic [31:0]              o_rd_stamp,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_irq,
  output logic [31:0]              o_capture_count,
  output logic [31:0]              o_drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Level constants sized to the level register so comparisons stay exact.
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] IRQ_L   = LW'(IRQ_THRESHOLD);
  localparam logic [31:0]   SAT_MAX = 32'hFFFF_FFFF;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]           ts_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic                  empty_q;
  logic                  full_q;
  logic                  irq_q;
  logic [31:0]           capture_q;
  logic [31:0]           drop_q;

  // Entry storage: no reset so it can map onto RAM.
  logic [DATA_WIDTH-1:0] data_mem  [DEPTH];
  logic [31:0]           stamp_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Per-cycle decisions
  // ---------------------------------------------------------------------------
  logic                  do_rd;
  logic                  do_wr;
  logic                  do_drop;
  logic [LW-1:0]         level_next;

  always_comb begin
    do_rd      = 1'b0;
    do_wr      = 1'b0;
    do_drop    = 1'b0;
    level_next = level_q;

    if (!i_flush) begin
      // A pop on empty is ignored, which also makes write+read on an empty
      // FIFO a plain write.
      do_rd   = i_rd_en && !empty_q;
      // On a full FIFO the same-cycle pop frees the slot being written.
      do_wr   = i_wr_valid && (!full_q || do_rd);
      do_drop = i_wr_valid && full_q && !do_rd;
      level_next = level_q + LW'(do_wr) - LW'(do_rd);
    end else begin
      level_next = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_fclk) begin
    if (!i_reset_n) begin
      ts_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      irq_q     <= 1'b0;
      capture_q <= '0;
      drop_q    <= '0;
    end else begin
      // Timestamp: free-running, wraps naturally at 32 bits.
      if (i_counter_reset) begin
        ts_q <= '0;
      end else begin
        ts_q <= ts_q + 32'd1;
      end

      // Pointers wrap modulo DEPTH because DEPTH is a power of two.
      if (i_flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_wr) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
        if (do_rd) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
      end

      // Flags are computed from the next level so all four agree each cycle.
      level_q <= level_next;
      empty_q <= (level_next == '0);
      full_q  <= (level_next == DEPTH_L);
      irq_q   <= (level_next >= IRQ_L);

      // Statistics: a clear in the same cycle as a capture wins.
      if (i_counter_reset) begin
        capture_q <= '0;
        drop_q    <= '0;
      end else begin
        if (do_wr && (capture_q != SAT_MAX)) begin
          capture_q <= capture_q + 32'd1;
        end
        if (do_drop && (drop_q != SAT_MAX)) begin
          drop_q <= drop_q + 32'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Entry RAM. The stamp is the counter value of the capture cycle, i.e. the
  // pre-clear value when i_counter_reset arrives together with the write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_fclk) begin
    if (i_reset_n && do_wr) begin
      data_mem[wr_ptr_q]  <= i_wr_data;
      stamp_mem[wr_ptr_q] <= ts_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: head entry shown combinationally from the read pointer.
  // ---------------------------------------------------------------------------
  assign o_rd_data       = data_mem[rd_ptr_q];
  assign o_rd_stamp      = stamp_mem[rd_ptr_q];
  assign o_empty         = empty_q;
  assign o_full          = full_q;
  assign o_level         = level_q;
  assign o_irq           = irq_q;
  assign o_capture_count = capture_q;
  assign o_drop_count    = drop_q;

endmodule

// File: doc/match_result_fifo.md
MATCH_RESULT_FIFO -- requirements
Module: match_result_fifo

Interface
- REQ-001: Parameter DATA_WIDTH, default 64, width of each captured match word.
- REQ-002: Parameter DEPTH, default 16, number of FIFO entries; must be a power of two, 2..256.
- REQ-003: Parameter IRQ_THRESHOLD, default 8, fill level at which o_irq asserts; must be in 1..DEPTH.
- REQ-004: i_fclk  in  1  sole clock; all logic on its rising edge.
- REQ-005: i_reset_n  in  1  reset, synchronous, active-low.
- REQ-006: i_wr_valid  in  1  capture strobe: one-cycle pulse per matched word from the matching controller (its result-reset pulse).
- REQ-007: i_wr_data  in  DATA_WIDTH  matched word, sampled when i_wr_valid=1.
- REQ-008: i_rd_en  in  1  pop request from the software-side register block.
- REQ-009: o_rd_data  out  DATA_WIDTH  head-entry data (first-word-fall-through).
- REQ-010: o_rd_stamp  out  32  head-entry timestamp.
- REQ-011: o_empty  out  1  FIFO holds no entries.
- REQ-012: o_full  out  1  FIFO holds DEPTH entries.
- REQ-013: o_level  out  $clog2(DEPTH)+1  current entry count.
- REQ-014: o_irq  out  1  level flag: o_level >= IRQ_THRESHOLD.
- REQ-015: i_flush  in  1  discard all entries.
- REQ-016: i_counter_reset  in  1  clear statistics and timestamp counters.
- REQ-017: o_capture_count  out  32  words accepted since the last clear.
- REQ-018: o_drop_count  out  32  words dropped because the FIFO was full.

Function
- REQ-019: Free-running 32-bit timestamp counter; increments every cycle; wraps 0xFFFFFFFF->0.
- REQ-020: Each entry stores {timestamp, data}; the timestamp is the counter value in the cycle i_wr_valid is sampled.
- REQ-021: Write accepted when i_wr_valid=1 and (not full, or full with a pop in the same cycle).
- REQ-022: Read pops the head when i_rd_en=1 and o_empty=0; i_rd_en with o_empty=1 is ignored with no state change.
- REQ-023: Write latency: word written in cycle N is visible at o_rd_data/o_rd_stamp with o_empty=0 from cycle N+1.
- REQ-024: o_rd_data/o_rd_stamp always show the head entry; value is don't-care while empty.
- REQ-025: Simultaneous write and read on an empty FIFO: write accepted, read ignored; level becomes 1.
- REQ-026: Simultaneous write and read on a full FIFO: both occur; level stays DEPTH; no drop.
- REQ-027: Simultaneous write and read otherwise: level unchanged.
- REQ-028: Write with full and no pop: word discarded; o_drop_count increments.
- REQ-029: Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from o_level.
- REQ-030: o_level, o_empty, o_full, o_irq are registered and consistent in the same cycle.
- REQ-031: o_capture_count increments by 1 per accepted write.
- REQ-032: Both statistics counters saturate at 0xFFFFFFFF.
- REQ-033: i_flush=1: next cycle, level=0, empty=1, and pointers=0.
  - A same-cycle write is discarded and not counted as capture or drop.
  - A same-cycle read is ignored.
  - Statistics are unchanged.
- REQ-034: i_counter_reset=1 clears both statistics counters and the timestamp counter to 0 next cycle; FIFO contents are untouched.
- REQ-035: i_counter_reset together with a write: the write is stored and counted as 0 (the clear wins), and the stamp is the pre-clear counter value.
- REQ-036: i_flush and i_counter_reset together: both take effect.

Reset
- REQ-037: i_reset_n=0 sampled at a clock edge sets:
  - pointers, level, all statistics and the timestamp counter to 0;
  - o_empty=1, o_full=0, o_irq=0.
- REQ-038: Reset mid-operation discards all stored entries; entry RAM contents need no reset.
- REQ-039: Reset has priority over i_flush, i_counter_reset, writes and reads.

Verification
- REQ-040: Release reset, write 0xA5 at timestamp 5, hold i_rd_en=0 -> next cycle o_empty=0, o_level=1, o_rd_data=0xA5, o_rd_stamp=5, o_capture_count=1.
- REQ-041: DEPTH=16, 18 writes, no reads -> o_full=1, o_level=16, o_drop_count=2, o_capture_count=16, o_irq=1 from level 8.
- REQ-042: Full FIFO, simultaneous write 0x77 and pop -> o_level=16, o_drop_count unchanged, 0x77 read last after 15 further pops.
- REQ-043: Empty FIFO, simultaneous write and pop -> o_level=1, o_empty=0; pop while empty alone -> no change.
- REQ-044: 10 entries, assert i_flush together with a write -> o_level=0, o_empty=0->1, capture and drop counts unchanged.
- REQ-045: 20 writes across pointer wrap with interleaved pops -> data and stamps emerge in write order; i_counter_reset -> counts 0, entries retained.
